// File: rtl/mem_arb.sv
// mem_arb: merges an instruction-fetch read port and a load/store port onto one
// single-port synchronous memory, round-robin under contention, 1-cycle read return.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif

module mem_arb (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_i_valid,
  input  logic [`HBIT_ADDR:0]   iw_i_addr,
  output logic                  ow_i_ready,
  output logic                  or_i_rvalid,
  output logic [`HBIT_DATA:0]   ow_i_rdata,
  input  logic                  iw_d_valid,
  input  logic                  iw_d_we,
  input  logic [`HBIT_ADDR:0]   iw_d_addr,
  input  logic [`HBIT_DATA:0]   iw_d_wdata,
  output logic                  ow_d_ready,
  output logic                  or_d_rvalid,
  output logic [`HBIT_DATA:0]   ow_d_rdata,
  output logic                  ow_mem_we,
  output logic [`HBIT_ADDR:0]   ow_mem_addr,
  output logic [`HBIT_DATA:0]   ow_mem_wdata,
  input  logic [`HBIT_DATA:0]   iw_mem_rdata,
  output logic [15:0]           or_conflicts
);

  localparam logic [0:0] LAST_I = 1'b0;
  localparam logic [0:0] LAST_D = 1'b1;

  logic [0:0] r_last;
  logic       contention;
  logic       grant_i;
  logic       grant_d;

  // Under contention the port not recorded in r_last wins; a lone requester always wins.
  assign contention = !iw_rst && iw_i_valid && iw_d_valid;
  assign grant_i    = !iw_rst && iw_i_valid && (!iw_d_valid || (r_last == LAST_D));
  assign grant_d    = !iw_rst && iw_d_valid && (!iw_i_valid || (r_last == LAST_I));

  assign ow_i_ready = grant_i;
  assign ow_d_ready = grant_d;

  always_comb begin
    ow_mem_we    = 1'b0;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    if (grant_i) begin
      ow_mem_addr = iw_i_addr;
    end else if (grant_d) begin
      ow_mem_we    = iw_d_we;
      ow_mem_addr  = iw_d_addr;
      ow_mem_wdata = iw_d_wdata;
    end
  end

  assign ow_i_rdata = iw_mem_rdata;
  assign ow_d_rdata = iw_mem_rdata;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_last       <= LAST_D;
      or_i_rvalid  <= 1'b0;
      or_d_rvalid  <= 1'b0;
      or_conflicts <= 16'h0000;
    end else begin
      or_i_rvalid <= grant_i;
      or_d_rvalid <= grant_d && !iw_d_we;
      if (contention) begin
        r_last <= grant_i ? LAST_I : LAST_D;
        if (or_conflicts != 16'hFFFF) begin
          or_conflicts <= or_conflicts + 16'h0001;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural read-before-write memory behind it.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif

module tb_mem_arb;

  logic                iw_clk = 1'b0;
  logic                iw_rst;
  logic                iw_i_valid;
  logic [`HBIT_ADDR:0] iw_i_addr;
  logic                ow_i_ready;
  logic                or_i_rvalid;
  logic [`HBIT_DATA:0] ow_i_rdata;
  logic                iw_d_valid;
  logic                iw_d_we;
  logic [`HBIT_ADDR:0] iw_d_addr;
  logic [`HBIT_DATA:0] iw_d_wdata;
  logic                ow_d_ready;
  logic                or_d_rvalid;
  logic [`HBIT_DATA:0] ow_d_rdata;
  logic                ow_mem_we;
  logic [`HBIT_ADDR:0] ow_mem_addr;
  logic [`HBIT_DATA:0] ow_mem_wdata;
  logic [`HBIT_DATA:0] iw_mem_rdata;
  logic [15:0]         or_conflicts;

  int checks = 0;
  int failures = 0;

  localparam logic [`HBIT_DATA:0] DATA_10 = 32'h1234_0010;

  logic [`HBIT_DATA:0] mem [0:(1<<(`HBIT_ADDR+1))-1];

  always #5 iw_clk = ~iw_clk;

  // Synchronous single-port memory, read-before-write.
  always @(posedge iw_clk) begin
    iw_mem_rdata <= mem[ow_mem_addr];
    if (ow_mem_we) mem[ow_mem_addr] <= ow_mem_wdata;
  end

  mem_arb dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_i_valid(iw_i_valid), .iw_i_addr(iw_i_addr), .ow_i_ready(ow_i_ready),
    .or_i_rvalid(or_i_rvalid), .ow_i_rdata(ow_i_rdata),
    .iw_d_valid(iw_d_valid), .iw_d_we(iw_d_we), .iw_d_addr(iw_d_addr),
    .iw_d_wdata(iw_d_wdata), .ow_d_ready(ow_d_ready),
    .or_d_rvalid(or_d_rvalid), .ow_d_rdata(ow_d_rdata),
    .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
    .iw_mem_rdata(iw_mem_rdata), .or_conflicts(or_conflicts)
  );

  task automatic next_cycle();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic idle_inputs();
    iw_i_valid = 1'b0; iw_i_addr = '0;
    iw_d_valid = 1'b0; iw_d_we = 1'b0; iw_d_addr = '0; iw_d_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    iw_rst = 1'b1;
    next_cycle();
    iw_rst = 1'b0;
  endtask

  task automatic test_reset();
    iw_rst = 1'b1;
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    iw_d_valid = 1'b1; iw_d_we = 1'b1; iw_d_addr = 12'h030; iw_d_wdata = 32'hDEAD;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ow_i_ready !== 1'b0 || ow_d_ready !== 1'b0 || ow_mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d i_ready=%b d_ready=%b mem_we=%b required 0 0 0",
                 c, ow_i_ready, ow_d_ready, ow_mem_we);
      end
      next_cycle();
    end
    iw_rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (or_i_rvalid !== 1'b0 || or_d_rvalid !== 1'b0 || or_conflicts !== 16'h0000) begin
      failures++;
      $display("FAIL reset_values i_rvalid=%b d_rvalid=%b conflicts=%h required 0 0 0000",
               or_i_rvalid, or_d_rvalid, or_conflicts);
    end
    checks++;
    if (ow_mem_addr !== '0 || ow_mem_wdata !== '0 || ow_i_ready !== 1'b0 || ow_d_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_drive addr=%h wdata=%h i_ready=%b d_ready=%b required 0 0 0 0",
               ow_mem_addr, ow_mem_wdata, ow_i_ready, ow_d_ready);
    end
    checks++;
    if (mem[12'h030] !== 32'h0) begin
      failures++;
      $display("FAIL reset_no_write mem[030]=%h required 00000000", mem[12'h030]);
    end
  endtask

  task automatic test_single_port();
    idle_inputs();
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    #1;
    checks++;
    if (ow_i_ready !== 1'b1 || ow_d_ready !== 1'b0 || ow_mem_addr !== 12'h010 || ow_mem_we !== 1'b0) begin
      failures++;
      $display("FAIL single_grant i_ready=%b d_ready=%b addr=%h we=%b required 1 0 010 0",
               ow_i_ready, ow_d_ready, ow_mem_addr, ow_mem_we);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (or_i_rvalid !== 1'b1 || ow_i_rdata !== DATA_10 || or_d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_resp i_rvalid=%b rdata=%h d_rvalid=%b required 1 %h 0",
               or_i_rvalid, ow_i_rdata, or_d_rvalid, DATA_10);
    end
    next_cycle();
    checks++;
    if (or_i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_resp_end i_rvalid=%b required 0", or_i_rvalid);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    iw_d_valid = 1'b1; iw_d_we = 1'b1; iw_d_addr = 12'h020; iw_d_wdata = 32'h0000_00A5;
    #1;
    checks++;
    if (ow_d_ready !== 1'b1 || ow_mem_we !== 1'b1 || ow_mem_addr !== 12'h020 || ow_mem_wdata !== 32'hA5) begin
      failures++;
      $display("FAIL wr_grant d_ready=%b we=%b addr=%h wdata=%h required 1 1 020 000000a5",
               ow_d_ready, ow_mem_we, ow_mem_addr, ow_mem_wdata);
    end
    next_cycle();
    iw_d_we = 1'b0;
    #1;
    checks++;
    if (ow_d_ready !== 1'b1 || ow_mem_we !== 1'b0 || or_d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_grant d_ready=%b we=%b d_rvalid=%b required 1 0 0",
               ow_d_ready, ow_mem_we, or_d_rvalid);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (or_d_rvalid !== 1'b1 || ow_d_rdata !== 32'hA5 || or_i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL raw_resp d_rvalid=%b rdata=%h i_rvalid=%b required 1 000000a5 0",
               or_d_rvalid, ow_d_rdata, or_i_rvalid);
    end
  endtask

  task automatic test_contention();
    logic exp_i [4];
    exp_i[0] = 1'b1; exp_i[1] = 1'b0; exp_i[2] = 1'b1; exp_i[3] = 1'b0;
    pulse_reset();
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    iw_d_valid = 1'b1; iw_d_we = 1'b0; iw_d_addr = 12'h020;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ow_i_ready !== exp_i[c] || ow_d_ready !== !exp_i[c]) begin
        failures++;
        $display("FAIL rr_grant cyc=%0d i_ready=%b d_ready=%b required %b %b",
                 c, ow_i_ready, ow_d_ready, exp_i[c], !exp_i[c]);
      end
      if (c > 0) begin
        checks++;
        if (or_i_rvalid !== exp_i[c-1] || or_d_rvalid !== !exp_i[c-1] ||
            ow_i_rdata !== (exp_i[c-1] ? DATA_10 : 32'hA5)) begin
          failures++;
          $display("FAIL rr_resp cyc=%0d i_rvalid=%b d_rvalid=%b rdata=%h",
                   c, or_i_rvalid, or_d_rvalid, ow_i_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (or_d_rvalid !== 1'b1 || ow_d_rdata !== 32'hA5 || or_i_rvalid !== 1'b0 || or_conflicts !== 16'd4) begin
      failures++;
      $display("FAIL rr_final d_rvalid=%b rdata=%h i_rvalid=%b conflicts=%0d required 1 000000a5 0 4",
               or_d_rvalid, ow_d_rdata, or_i_rvalid, or_conflicts);
    end
  endtask

  task automatic test_uncontended_keeps_last();
    pulse_reset();
    iw_d_valid = 1'b1; iw_d_we = 1'b0; iw_d_addr = 12'h020;
    next_cycle();
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    #1;
    checks++;
    if (ow_i_ready !== 1'b1 || ow_d_ready !== 1'b0 || or_conflicts !== 16'd0) begin
      failures++;
      $display("FAIL uncontended_last i_ready=%b d_ready=%b conflicts=%0d required 1 0 0",
               ow_i_ready, ow_d_ready, or_conflicts);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (or_conflicts !== 16'd1) begin
      failures++;
      $display("FAIL uncontended_count conflicts=%0d required 1", or_conflicts);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    iw_d_valid = 1'b1; iw_d_we = 1'b0; iw_d_addr = 12'h020;
    for (int c = 0; c < 65534; c++) next_cycle();
    checks++;
    if (or_conflicts !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_pre conflicts=%h required fffe", or_conflicts);
    end
    for (int c = 0; c < 6; c++) next_cycle();
    checks++;
    if (or_conflicts !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold conflicts=%h required ffff", or_conflicts);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    pulse_reset();
    iw_i_valid = 1'b1; iw_i_addr = 12'h010;
    #1;
    checks++;
    if (ow_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_grant i_ready=%b required 1", ow_i_ready);
    end
    next_cycle();
    iw_rst = 1'b1;
    iw_d_valid = 1'b1; iw_d_we = 1'b1; iw_d_addr = 12'h040; iw_d_wdata = 32'hBEEF;
    #1;
    checks++;
    if (or_i_rvalid !== 1'b1 || ow_i_rdata !== DATA_10 || ow_i_ready !== 1'b0 ||
        ow_d_ready !== 1'b0 || ow_mem_we !== 1'b0) begin
      failures++;
      $display("FAIL midrst_cycle i_rvalid=%b rdata=%h i_ready=%b d_ready=%b we=%b required 1 %h 0 0 0",
               or_i_rvalid, ow_i_rdata, ow_i_ready, ow_d_ready, ow_mem_we, DATA_10);
    end
    next_cycle();
    iw_rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (or_i_rvalid !== 1'b0 || mem[12'h040] !== 32'h0) begin
      failures++;
      $display("FAIL midrst_after i_rvalid=%b mem[040]=%h required 0 00000000",
               or_i_rvalid, mem[12'h040]);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << (`HBIT_ADDR + 1)); a++) mem[a] = '0;
    mem[12'h010] = DATA_10;
    idle_inputs();
    iw_rst = 1'b1;
    @(posedge iw_clk);
    #1;
    test_reset();
    test_single_port();
    test_write_read();
    test_contention();
    test_uncontended_keeps_last();
    test_reset_mid_read();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port request arbiter sitting directly upstream of the single-port synchronous data memory. Merges an instruction-fetch read port (I) and a load/store port (D) onto the memory's single we/addr/wdata interface, one access per cycle. Routes the memory's one-cycle-latency read data back to the requesting port, and counts contention cycles for performance monitoring.

## Interface
- No parameters. Widths come from `sizes.vh`: address `HBIT_ADDR+1` bits, data `HBIT_DATA+1` bits.
- iw_clk  in  1  clock, all logic on rising edge
- iw_rst  in  1  synchronous reset, active-high
- iw_i_valid  in  1  I-port read request
- iw_i_addr  in  `HBIT_ADDR+1`  I-port address
- ow_i_ready  out  1  I request accepted this cycle (combinational)
- or_i_rvalid  out  1  I read data valid this cycle
- ow_i_rdata  out  `HBIT_DATA+1`  I read data, meaningful only with or_i_rvalid
- iw_d_valid  in  1  D-port request
- iw_d_we  in  1  D request is a write (1) or read (0)
- iw_d_addr  in  `HBIT_ADDR+1`  D-port address
- iw_d_wdata  in  `HBIT_DATA+1`  D write data
- ow_d_ready  out  1  D request accepted this cycle (combinational)
- or_d_rvalid  out  1  D read data valid this cycle
- ow_d_rdata  out  `HBIT_DATA+1`  D read data, meaningful only with or_d_rvalid
- ow_mem_we  out  1  memory write enable
- ow_mem_addr  out  `HBIT_ADDR+1`  memory address
- ow_mem_wdata  out  `HBIT_DATA+1`  memory write data
- iw_mem_rdata  in  `HBIT_DATA+1`  memory registered read data (valid one cycle after address)
- or_conflicts  out  16  saturating count of contention cycles

## Operation
- **Transfer rule:** a transfer occurs on a port when valid && ready in the same cycle. Ready is a pure function of both valids, r_last and iw_rst. Ready never depends on the same port's own ready.
- **One valid only:** that port gets ready=1.
- **Both valid (contention):** round-robin. Grant the port not recorded in r_last. On each contention grant:
  - update r_last to the winner;
  - increment or_conflicts, saturating at 0xFFFF.
- **Neither valid:** both readies 0.
- **Uncontended grants** do not change r_last.
- **Memory drive when granted:**
  - I grant: ow_mem_addr=iw_i_addr, ow_mem_we=0.
  - D grant: ow_mem_addr=iw_d_addr, ow_mem_we=iw_d_we, ow_mem_wdata=iw_d_wdata.
- **Memory drive when idle:** ow_mem_we=0, ow_mem_addr=0, ow_mem_wdata=0.
- **Response tag:**
  - or_i_rvalid <= I granted.
  - or_d_rvalid <= D granted && !iw_d_we.
  - Writes produce no response; acceptance (ready) is the completion.
- **Read data:** ow_i_rdata and ow_d_rdata both pass iw_mem_rdata through combinationally. They are qualified only by the matching rvalid.
- **No backpressure on responses:** the requester must sink read data in the cycle rvalid is high.
- **While iw_rst=1:** both readies forced 0 and ow_mem_we forced 0.
- **Reset values:** or_i_rvalid=0, or_d_rvalid=0, or_conflicts=0, r_last=D (first contention after reset grants I).
- **Reset mid-operation:** a read granted in the cycle before reset still drives its rvalid in the reset cycle. A read cannot be granted in the reset cycle, so rvalid=0 in the cycle after reset. No write reaches memory during reset.

## Timing
- Grant: combinational, cycle N.
- Read response: rvalid high in cycle N+1 with the memory data. Latency is 1 cycle per read.
- Throughput: one access per cycle total, back-to-back grants allowed.
- Sustained contention: grants alternate I, D, I, D…; or_conflicts increments every such cycle.
- Read-after-write: D write to address A in cycle N, followed by any read of A granted in N+1, returns the new data in N+2.
- Same-cycle read/write: the memory's read-before-write behaviour applies. Since only one port is granted per cycle, no same-cycle hazard exists within the arbiter.

## Test plan
- **Reset:** assert iw_rst for 2 cycles with iw_i_valid=iw_d_valid=1 -> readies 0, ow_mem_we 0; after release all rvalids 0 and or_conflicts=0.
- **Single port:** I read of 0x010 only -> ow_i_ready=1 in cycle N; or_i_rvalid=1 in N+1 with memory content of 0x010; or_d_rvalid stays 0.
- **Write then read:** D write 0x020 <- 0xA5 in N, D read 0x020 in N+1 -> ow_mem_we=1 in N only; or_d_rvalid in N+2 with data 0xA5.
- **Contention:** both valid for 4 cycles right after reset -> grant order I, D, I, D; or_conflicts=4; rvalids follow each read grant one cycle later.
- **Saturation:** hold contention for 65540 cycles -> or_conflicts stops at 0xFFFF.
- **Reset mid-read:** I read granted in N, iw_rst high in N+1 -> or_i_rvalid=1 in N+1, 0 in N+2; no ready during reset.
